// File: rtl/ecg_dsp_pkg.sv
// Shared types and default widths for the ECG moving-average datapath.
package ecg_dsp_pkg;

  localparam int DATA_WIDTH    = 11;
  localparam int MA_LONG_LOG2  = 5;
  localparam int MA_SHORT_LOG2 = 3;

  typedef enum logic [1:0] {
    FILL_SHORT,
    FILL_LONG,
    RUN
  } ma_state_t;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/ma_ring_buffer.sv
// Circular sample store shared by both windows. The write pointer marks the
// slot about to be overwritten, which is also the oldest long-window sample.
module ma_ring_buffer #(
  parameter int DATA_WIDTH = ecg_dsp_pkg::DATA_WIDTH,
  parameter int LONG_LOG2  = ecg_dsp_pkg::MA_LONG_LOG2,
  parameter int SHORT_LOG2 = ecg_dsp_pkg::MA_SHORT_LOG2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] tap_long,
  output logic signed [DATA_WIDTH-1:0] tap_short
);

  localparam int DEPTH = 1 << LONG_LOG2;
  localparam int SHORT_LEN_I = 1 << SHORT_LOG2;
  localparam logic [LONG_LOG2-1:0] SHORT_OFF = SHORT_LEN_I[LONG_LOG2-1:0];
  localparam logic [LONG_LOG2-1:0] PTR_ONE   = 1;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LONG_LOG2-1:0]         wr_ptr;
  logic [LONG_LOG2-1:0]         short_idx;

  // Short tap sits 2^SHORT_LOG2 slots behind the write pointer, wrapping mod depth.
  assign short_idx = wr_ptr - SHORT_OFF;
  assign tap_long  = mem[wr_ptr];
  assign tap_short = mem[short_idx];

  // Write pointer advances once per accepted sample; restart rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_ptr <= '0;
    else if (clr)   wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
  end

  // Sample storage is never cleared; the fill logic masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dual_moving_avg.sv
// Short- and long-window moving averages of the ECG stream, emitted together
// with the sample that produced them. Running sums are updated incrementally.
module dual_moving_avg #(
  parameter int DATA_WIDTH = ecg_dsp_pkg::DATA_WIDTH,
  parameter int LONG_LOG2  = ecg_dsp_pkg::MA_LONG_LOG2,
  parameter int SHORT_LOG2 = ecg_dsp_pkg::MA_SHORT_LOG2
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_ce,
  input  logic                         i_clr,
  input  logic signed [DATA_WIDTH-1:0] i_ecg_sample,
  output logic signed [DATA_WIDTH-1:0] o_ecg_sample,
  output logic signed [DATA_WIDTH-1:0] o_ma_short,
  output logic signed [DATA_WIDTH-1:0] o_ma_long,
  output logic                         o_ma_short_valid,
  output logic                         o_ma_long_valid
);

  import ecg_dsp_pkg::*;

  localparam int SUM_S_W     = DATA_WIDTH + SHORT_LOG2;
  localparam int SUM_L_W     = DATA_WIDTH + LONG_LOG2;
  localparam int SHORT_LEN_I = 1 << SHORT_LOG2;
  localparam int LONG_LEN_I  = 1 << LONG_LOG2;
  localparam int SHORT_END_I = SHORT_LEN_I - 1;
  localparam int LONG_END_I  = LONG_LEN_I - 1;
  localparam logic [LONG_LOG2:0] SHORT_LAST = SHORT_END_I[LONG_LOG2:0];
  localparam logic [LONG_LOG2:0] LONG_LAST  = LONG_END_I[LONG_LOG2:0];
  localparam logic [LONG_LOG2:0] LONG_LEN   = LONG_LEN_I[LONG_LOG2:0];
  localparam logic [LONG_LOG2:0] FILL_ONE   = 1;

  // Floor mean of the short window (arithmetic shift rounds toward -inf).
  function automatic logic signed [DATA_WIDTH-1:0] mean_short(
    input logic signed [SUM_S_W-1:0] s
  );
    logic signed [SUM_S_W-1:0] q;
    q = s >>> SHORT_LOG2;
    return q[DATA_WIDTH-1:0];
  endfunction

  // Floor mean of the long window.
  function automatic logic signed [DATA_WIDTH-1:0] mean_long(
    input logic signed [SUM_L_W-1:0] s
  );
    logic signed [SUM_L_W-1:0] q;
    q = s >>> LONG_LOG2;
    return q[DATA_WIDTH-1:0];
  endfunction

  ma_state_t                    state, state_nxt;
  logic [LONG_LOG2:0]           fill;
  logic signed [SUM_S_W-1:0]    sum_short, sum_short_nxt;
  logic signed [SUM_L_W-1:0]    sum_long, sum_long_nxt;
  logic signed [DATA_WIDTH-1:0] tap_short, tap_long;
  logic signed [DATA_WIDTH-1:0] old_short, old_long;
  logic                         accept, short_full_nxt, long_full_nxt;

  logic signed [DATA_WIDTH-1:0] ecg_p1, ma_short_p1, ma_long_p1;
  logic                         vld_short_p1, vld_long_p1;

  assign accept = i_ce & ~i_clr;

  ma_ring_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LONG_LOG2  (LONG_LOG2),
    .SHORT_LOG2 (SHORT_LOG2)
  ) u_ring (
    .clk       (i_clk),
    .rst_n     (i_nrst),
    .clr       (i_clr),
    .wr_en     (accept),
    .wr_data   (i_ecg_sample),
    .tap_long  (tap_long),
    .tap_short (tap_short)
  );

  // Next fill state and next running sums; oldest taps count only once a window is full.
  always_comb begin
    state_nxt     = state;
    old_short     = '0;
    old_long      = '0;
    sum_short_nxt = sum_short;
    sum_long_nxt  = sum_long;
    if (state != FILL_SHORT) old_short = tap_short;
    if (state == RUN)        old_long  = tap_long;
    if (i_clr) begin
      state_nxt = FILL_SHORT;
    end else if (i_ce) begin
      sum_short_nxt = sum_short + SUM_S_W'(i_ecg_sample) - SUM_S_W'(old_short);
      sum_long_nxt  = sum_long  + SUM_L_W'(i_ecg_sample) - SUM_L_W'(old_long);
      case (state)
        FILL_SHORT: if (fill == SHORT_LAST) state_nxt = FILL_LONG;
        FILL_LONG:  if (fill == LONG_LAST)  state_nxt = RUN;
        default:    state_nxt = RUN;
      endcase
    end
  end

  assign short_full_nxt = accept && (state_nxt != FILL_SHORT);
  assign long_full_nxt  = accept && (state_nxt == RUN);

  // Fill state register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= FILL_SHORT;
    else         state <= state_nxt;
  end

  // Running sums, fill counter and the output stage, all updated on accepted samples.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sum_short    <= '0;
      sum_long     <= '0;
      fill         <= '0;
      ecg_p1       <= '0;
      ma_short_p1  <= '0;
      ma_long_p1   <= '0;
      vld_short_p1 <= 1'b0;
      vld_long_p1  <= 1'b0;
    end else if (i_clr) begin
      sum_short    <= '0;
      sum_long     <= '0;
      fill         <= '0;
      ma_short_p1  <= '0;
      ma_long_p1   <= '0;
      vld_short_p1 <= 1'b0;
      vld_long_p1  <= 1'b0;
    end else if (i_ce) begin
      sum_short    <= sum_short_nxt;
      sum_long     <= sum_long_nxt;
      if (fill != LONG_LEN) fill <= fill + FILL_ONE;
      ecg_p1       <= i_ecg_sample;
      ma_short_p1  <= short_full_nxt ? mean_short(sum_short_nxt) : '0;
      ma_long_p1   <= long_full_nxt  ? mean_long(sum_long_nxt)   : '0;
      vld_short_p1 <= short_full_nxt;
      vld_long_p1  <= long_full_nxt;
    end else begin
      vld_short_p1 <= 1'b0;
      vld_long_p1  <= 1'b0;
    end
  end

  assign o_ecg_sample     = ecg_p1;
  assign o_ma_short       = ma_short_p1;
  assign o_ma_long        = ma_long_p1;
  assign o_ma_short_valid = vld_short_p1;
  assign o_ma_long_valid  = vld_long_p1;

endmodule

// File: tb/tb_dual_moving_avg.sv
// Scoreboard bench for dual_moving_avg: a window model of accepted samples
// queues the expected strobe outputs; a monitor compares on every strobe.
module tb_dual_moving_avg;

  localparam int DW = 11;

  logic                 i_clk = 1'b0;
  logic                 i_nrst = 1'b1;
  logic                 i_ce = 1'b0;
  logic                 i_clr = 1'b0;
  logic signed [DW-1:0] i_ecg_sample = '0;
  logic signed [DW-1:0] o_ecg_sample, o_ma_short, o_ma_long;
  logic                 o_ma_short_valid, o_ma_long_valid;

  dual_moving_avg #(.DATA_WIDTH(DW), .LONG_LOG2(5), .SHORT_LOG2(3)) dut (
    .i_clk            (i_clk),
    .i_nrst           (i_nrst),
    .i_ce             (i_ce),
    .i_clr            (i_clr),
    .i_ecg_sample     (i_ecg_sample),
    .o_ecg_sample     (o_ecg_sample),
    .o_ma_short       (o_ma_short),
    .o_ma_long        (o_ma_long),
    .o_ma_short_valid (o_ma_short_valid),
    .o_ma_long_valid  (o_ma_long_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int sample;
    int ms;
    int ml;
    int vs;
    int vl;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   nacc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Mean of the most recent n accepted samples, floored toward -inf.
  function automatic int floor_mean(input int n);
    int s = 0;
    for (int k = hist.size() - n; k < hist.size(); k++) s += hist[k];
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  task automatic model_accept(input int x);
    exp_t e;
    hist.push_back(x);
    if (hist.size() > 32) void'(hist.pop_front());
    nacc++;
    e.sample = x;
    e.vs     = (nacc >= 8)  ? 1 : 0;
    e.vl     = (nacc >= 32) ? 1 : 0;
    e.ms     = e.vs ? floor_mean(8)  : 0;
    e.ml     = e.vl ? floor_mean(32) : 0;
    if (e.vs != 0) exp_q.push_back(e);
  endtask

  task automatic model_clear();
    hist.delete();
    nacc = 0;
  endtask

  // One clock of stimulus; the model sees exactly what the edge accepted.
  task automatic drive(input bit ce, input bit clr, input int x);
    i_ce = ce;
    i_clr = clr;
    i_ecg_sample = DW'(x);
    @(posedge i_clk);
    if (clr) model_clear();
    else if (ce) model_accept(x);
    #1;
    i_ce = 1'b0;
    i_clr = 1'b0;
  endtask

  task automatic run_const(input int n, input int x);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, x);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ecg"}, int'(o_ecg_sample), 0);
    chk({tag, "_ma_short"}, int'(o_ma_short), 0);
    chk({tag, "_ma_long"}, int'(o_ma_long), 0);
    chk({tag, "_vs"}, int'(o_ma_short_valid), 0);
    chk({tag, "_vl"}, int'(o_ma_long_valid), 0);
  endtask

  // Monitor: every strobe must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_ma_short_valid || o_ma_long_valid) begin
        if (exp_q.size() == 0) begin
          chk("strobe_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("ecg_sample", int'(o_ecg_sample), e.sample);
          chk("ma_short", int'(o_ma_short), e.ms);
          chk("ma_long", int'(o_ma_long), e.ml);
          chk("short_valid", int'(o_ma_short_valid), e.vs);
          chk("long_valid", int'(o_ma_long_valid), e.vl);
        end
      end
    end
  end

  initial begin
    int x;
    // Reset state
    #2 i_nrst = 1'b0;
    #1 check_zero("reset");
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(posedge i_clk);
    #1;

    // Constant 100: short strobe from sample 8, long from sample 32
    run_const(7, 100);
    chk("fill7_vs", int'(o_ma_short_valid), 0);
    chk("fill7_ma_short", int'(o_ma_short), 0);
    chk("fill7_ecg", int'(o_ecg_sample), 100);
    run_const(33, 100);

    // Floor behaviour of the short mean
    drive(1'b0, 1'b1, 0);
    run_const(7, 0);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 0);
    run_const(7, 0);
    drive(1'b1, 1'b0, -1);

    // Extremes
    drive(1'b0, 1'b1, 0);
    run_const(32, 1023);
    drive(1'b0, 1'b1, 0);
    run_const(32, -1024);
    drive(1'b0, 1'b1, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 1023);
      drive(1'b1, 1'b0, -1024);
    end

    // Random acceptance pattern and random samples
    drive(1'b0, 1'b1, 0);
    for (int k = 0; k < 200; k++) begin
      x = int'($urandom_range(2047)) - 1024;
      drive(($urandom_range(99) < 60) ? 1'b1 : 1'b0, 1'b0, x);
    end

    // Restart coinciding with an accepted sample
    drive(1'b0, 1'b1, 0);
    for (int k = 1; k <= 19; k++) drive(1'b1, 1'b0, k * 3);
    drive(1'b1, 1'b1, 500);
    chk("clr_vs", int'(o_ma_short_valid), 0);
    chk("clr_vl", int'(o_ma_long_valid), 0);
    chk("clr_ma_short", int'(o_ma_short), 0);
    chk("clr_ecg_hold", int'(o_ecg_sample), 57);
    for (int k = 0; k < 40; k++) drive(1'b1, 1'b0, int'($urandom_range(2047)) - 1024);

    // Asynchronous reset between edges
    drive(1'b0, 1'b0, 0);
    #2 i_nrst = 1'b0;
    #1 check_zero("async_rst");
    model_clear();
    @(negedge i_clk);
    #1 i_nrst = 1'b1;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 40; k++) drive(1'b1, 1'b0, int'($urandom_range(2047)) - 1024);

    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_moving_avg.md
# dual_moving_avg

Streaming producer of the short- and long-window moving averages of the ECG sample stream. It drives the MA side of the absolute-difference stage. Per accepted sample it emits the registered sample and both window means, all taken from the same sample, plus per-window valid strobes. One circular buffer holds both windows, and running sums are updated incrementally (add newest, subtract oldest).

## Interface
Parameters:
- `DATA_WIDTH`, 11, signed sample width (two's complement).
- `LONG_LOG2`, 5, log2 of long window length (32 samples).
- `SHORT_LOG2`, 3, log2 of short window length (8 samples). Must be less than `LONG_LOG2`.

Ports:
- `i_clk` in 1: the single clock; everything is on the rising edge.
- `i_nrst` in 1: reset, asynchronous and active-low.
- `i_ce` in 1: sample-accept strobe; one new sample per cycle where high.
- `i_clr` in 1: synchronous restart of both windows.
- `i_ecg_sample` in `DATA_WIDTH`, signed: input sample, sampled when `i_ce` is high.
- `o_ecg_sample` out `DATA_WIDTH`, signed: registered copy of the last accepted sample.
- `o_ma_short` out `DATA_WIDTH`, signed: short-window mean.
- `o_ma_long` out `DATA_WIDTH`, signed: long-window mean.
- `o_ma_short_valid` out 1: one-cycle strobe; short window is full.
- `o_ma_long_valid` out 1: one-cycle strobe; long window is full.

## Operation
Storage and pointers:
- Ring buffer has 2^`LONG_LOG2` entries of `DATA_WIDTH` bits, with asynchronous (combinational) read.
- Write pointer `wr_ptr` is `LONG_LOG2` bits and wraps naturally.
- Short-window oldest tap is `buf[wr_ptr - 2^SHORT_LOG2]`, modulo buffer size.
- Long-window oldest tap is `buf[wr_ptr]`, read before it is overwritten.

Sums:
- `sum_short` is signed, `DATA_WIDTH+SHORT_LOG2` bits.
- `sum_long` is signed, `DATA_WIDTH+LONG_LOG2` bits.
- Both are exact; no overflow is possible.

Accepted sample (`i_ce`=1, `i_clr`=0):
- `sum_x <= sum_x + x - oldest_x`. `oldest_x` is forced to 0 while that window is still filling; buffer contents are never reset.
- `buf[wr_ptr] <= x`, `wr_ptr++`, fill counter `fill` increments and saturates at 2^`LONG_LOG2`.

Mean: `o_ma_x` = new `sum_x` >>> log2 window. This is an arithmetic shift and floors toward −inf.

Fill state machine:
- FILL_SHORT: `fill` < 2^`SHORT_LOG2`.
- FILL_LONG: short window full, long window not yet full.
- RUN: both windows full.
- Transitions happen on the accepting edge that completes each window.
- `i_clr` returns the FSM to FILL_SHORT from any state.

Valid strobes:
- `o_ma_short_valid` pulses for one cycle after each accepted sample once the short window is full, i.e. on the 2^`SHORT_LOG2`th sample and every sample after.
- `o_ma_long_valid` follows the same rule with 2^`LONG_LOG2`.
- A sample that completes a window produces a valid strobe on that same output update.

Outputs without a strobe:
- Cycles without an accepted sample: valids 0; data outputs hold.
- Accepted sample in a still-filling window: that window's valid is 0 and its `o_ma_x` is 0.

`i_clr` behaviour:
- `i_clr`=1 zeroes `sum_*`, `wr_ptr`, `fill`, valids and `o_ma_*`.
- `i_clr` wins over a simultaneous `i_ce`; that sample is discarded.
- `o_ecg_sample` holds.

Reset (`i_nrst`=0, asynchronous):
- All outputs 0, sums 0, `wr_ptr` 0, `fill` 0, FSM in FILL_SHORT.
- Reset mid-stream discards the windows; refill starts from scratch.

## Timing
- Latency: one clock from the `i_ce` edge to the updated `o_ecg_sample`/`o_ma_*`/valids.
- All outputs registered together: `o_ecg_sample` is the same sample whose inclusion produced `o_ma_*`, so the downstream difference stage pairs them directly.
- Full throughput: `i_ce` may be high every cycle. Gaps of any length are allowed and do not disturb window contents.
- Long-tap read and write to the same entry on one edge: the read returns the old value (read-before-write).

## Structure
- Shared package `ecg_dsp_pkg` holds:
  - `DATA_WIDTH`, default window log2 constants;
  - the `ma_state_t` enum (FILL_SHORT, FILL_LONG, RUN);
  - a `sample_t` signed typedef.
- Sub-module `ma_ring_buffer` contains:
  - the register array, `wr_ptr` and write port;
  - two combinational read taps: offset 0 and offset −2^`SHORT_LOG2`.
- The top level holds the sums, fill counter, FSM and output registers.

## Test plan
1. Reset, then 40 samples of constant 100 with `i_ce`=1 every cycle:
   - first `o_ma_short_valid` is after sample 8, with `o_ma_short`=100;
   - first `o_ma_long_valid` is after sample 32, with `o_ma_long`=100;
   - no valid strobe earlier.
2. Seven samples of 0 then one sample of 1: `o_ma_short`=0 (1>>>3). Seven 0 then one −1: `o_ma_short`=−1 (floor).
3. Extreme values:
   - 32× 1023 gives `o_ma_long`=1023;
   - 32× −1024 gives `o_ma_long`=−1024;
   - alternating 1023/−1024 over 32 samples gives −1 (sum −16, >>>5).
4. `i_ce` toggled pseudo-randomly over 200 samples:
   - outputs and valids match a reference model fed only the accepted samples;
   - valid strobes appear only one cycle after accepting edges.
5. `i_clr` asserted with `i_ce` at sample 20:
   - that sample is discarded and valids drop;
   - next short valid comes after 8 further samples; next long valid after 32.
6. `i_nrst` pulsed low mid-run, asynchronously between edges: all outputs read 0 immediately, and a 32-sample refill is required before `o_ma_long_valid`.
